// File: rtl/mem_port_arbiter.sv
// Single-port arbiter sharing one unified memory between fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant every STARVE_MAX.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              control_memwrite,
    output logic              control_memread,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     r_state;
    logic       r_owner_d;
    logic [3:0] r_starve;
    logic [3:0] r_cnt;

    logic w_gnt_d;
    logic w_gnt_if;

    // Data wins unless a waiting fetch has already been passed over STARVE_MAX times
    assign w_gnt_d  = d_req && (!if_req || (r_starve < 4'(STARVE_MAX)));
    assign w_gnt_if = if_req && !w_gnt_d;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state          <= IDLE;
            r_owner_d        <= 1'b0;
            r_starve         <= 4'd0;
            r_cnt            <= 4'd0;
            if_gnt           <= 1'b0;
            d_gnt            <= 1'b0;
            if_rvalid        <= 1'b0;
            d_rvalid         <= 1'b0;
            if_rdata         <= '0;
            d_rdata          <= '0;
            mem_address      <= '0;
            mem_data_in      <= '0;
            control_memwrite <= 1'b0;
            control_memread  <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_d) begin
                        r_owner_d        <= 1'b1;
                        r_starve         <= if_req ? r_starve + 4'd1 : 4'd0;
                        mem_address      <= d_addr;
                        mem_data_in      <= d_wdata;
                        control_memwrite <= d_we;
                        control_memread  <= !d_we;
                        d_gnt            <= 1'b1;
                        r_cnt            <= 4'(MEM_LAT);
                        r_state          <= ACCESS;
                    end else if (w_gnt_if) begin
                        r_owner_d        <= 1'b0;
                        r_starve         <= 4'd0;
                        mem_address      <= if_addr;
                        mem_data_in      <= '0;
                        control_memwrite <= 1'b0;
                        control_memread  <= 1'b1;
                        if_gnt           <= 1'b1;
                        r_cnt            <= 4'(MEM_LAT);
                        r_state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd1) begin
                        r_state          <= IDLE;
                        control_memwrite <= 1'b0;
                        control_memread  <= 1'b0;
                        if (r_owner_d) begin
                            d_rvalid <= 1'b1;
                            if (!control_memwrite)
                                d_rdata <= mem_data_out;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_address[2] ? mem_data_out[63:32]
                                                        : mem_data_out[31:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard of expected responses.
// A small behavioural memory answers reads and absorbs writes.
module tb_mem_port_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [63:0] d_rdata;
    logic [63:0] mem_address, mem_data_in, mem_data_out;
    logic        control_memwrite, control_memread;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    logic [63:0] mem [16];

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .control_memwrite(control_memwrite), .control_memread(control_memread),
        .mem_data_out(mem_data_out)
    );

    always #5 CLOCK = ~CLOCK;

    assign mem_data_out = mem[mem_address[6:3]];

    always @(posedge CLOCK) begin
        cyc <= cyc + 1;
        if (control_memwrite)
            mem[mem_address[6:3]] <= mem_data_in;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Response monitor: every rvalid pops the oldest expected response
    always @(negedge CLOCK) begin
        if (!RESET && (if_rvalid || d_rvalid)) begin
            exp_t e;
            chk("one_rvalid", {63'd0, if_rvalid & d_rvalid}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rvalid_owner", {63'd0, d_rvalid}, {63'd0, e.is_d});
                if (e.is_d)
                    chk("d_rdata", d_rdata, e.data);
                else
                    chk("if_rdata", {32'd0, if_rdata}, e.data);
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return {55'd0, if_gnt, d_gnt, if_rvalid, d_rvalid,
                control_memread, control_memwrite,
                |mem_address, |mem_data_in, |if_rdata} | {1'b0, |d_rdata, 62'd0};
    endfunction

    initial begin
        int last;
        int w;
        bit fetch_turn;

        for (int i = 0; i < 16; i++) mem[i] = 64'h1111_0000_0000_0000 + 64'(i);
        mem[8] = 64'hDEADBEEF_CAFEF00D;
        mem[0] = 64'hAAAAAAAA_55555555;

        tick();
        tick();
        chk("reset_outs", all_outs(), 64'd0);
        RESET = 1'b0;

        // Lone load
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
        sb.push_back('{1'b1, 64'hDEADBEEF_CAFEF00D});
        tick();
        chk("load_gnt", {62'd0, if_gnt, d_gnt}, 64'd1);
        chk("load_rd_c1", {62'd0, control_memread, control_memwrite}, 64'd2);
        chk("load_addr", mem_address, 64'h40);
        d_req = 1'b0;
        tick();
        chk("load_rd_c2", {62'd0, control_memread, d_gnt}, 64'd2);
        chk("load_no_rv_c2", {63'd0, d_rvalid}, 64'd0);
        tick();
        chk("load_rv_c3", {62'd0, d_rvalid, control_memread}, 64'd2);

        // Store: d_rdata must keep the previous load value
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h10; d_wdata = 64'h1234;
        sb.push_back('{1'b1, 64'hDEADBEEF_CAFEF00D});
        tick();
        chk("store_gnt", {63'd0, d_gnt}, 64'd1);
        chk("store_wr_c1", {62'd0, control_memread, control_memwrite}, 64'd1);
        chk("store_wdata", mem_data_in, 64'h1234);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("store_wr_c2", {63'd0, control_memwrite}, 64'd1);
        tick();
        chk("store_rv", {62'd0, d_rvalid, control_memwrite}, 64'd2);

        // Fetch upper and lower word
        if_req = 1'b1; if_addr = 64'h4;
        sb.push_back('{1'b0, 64'hAAAAAAAA});
        tick();
        chk("fetch_gnt", {62'd0, if_gnt, d_gnt}, 64'd2);
        chk("fetch_wdata0", mem_data_in, 64'd0);
        chk("fetch_rd", {62'd0, control_memread, control_memwrite}, 64'd2);
        if_req = 1'b0;
        tick();
        tick();
        chk("fetch_rv", {63'd0, if_rvalid}, 64'd1);
        if_req = 1'b1; if_addr = 64'h0;
        sb.push_back('{1'b0, 64'h55555555});
        tick();
        chk("fetch2_gnt", {63'd0, if_gnt}, 64'd1);
        if_req = 1'b0;
        tick();
        tick();
        chk("fetch2_rv", {63'd0, if_rvalid}, 64'd1);

        // Starvation: both held, expect D D D D F D D D D F
        if_req = 1'b1; if_addr = 64'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
        for (int g = 0; g < 10; g++) begin
            fetch_turn = (g == 4) || (g == 9);
            sb.push_back(fetch_turn ? '{1'b0, 64'hAAAAAAAA} : '{1'b1, 64'h1234});
        end
        last = 0;
        for (int g = 0; g < 10; g++) begin
            fetch_turn = (g == 4) || (g == 9);
            w = 0;
            do begin
                tick();
                w++;
            end while (!if_gnt && !d_gnt && w < 8);
            chk($sformatf("starve_gnt%0d", g), {62'd0, if_gnt, d_gnt},
                fetch_turn ? 64'd2 : 64'd1);
            if (g > 0) chk($sformatf("starve_gap%0d", g), 64'(cyc - last), 64'd3);
            last = cyc;
            if (g == 9) begin
                if_req = 1'b0;
                d_req = 1'b0;
            end
        end
        tick();
        tick();
        tick();
        chk("starve_drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of a load, with a fetch pending
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
        tick();
        chk("mid_gnt", {63'd0, d_gnt}, 64'd1);
        d_req = 1'b0;
        if_req = 1'b1; if_addr = 64'h0;
        tick();
        RESET = 1'b1;
        #1;
        chk("mid_reset_outs", all_outs(), 64'd0);
        tick();
        chk("mid_reset_hold", all_outs(), 64'd0);
        RESET = 1'b0;
        sb.push_back('{1'b0, 64'h55555555});
        tick();
        chk("post_reset_fgnt", {62'd0, if_gnt, d_gnt}, 64'd2);
        if_req = 1'b0;
        tick();
        tick();
        chk("post_reset_rv", {63'd0, if_rvalid}, 64'd1);
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that lets the superscalar LEGv8 core's instruction-fetch unit and load/store unit share one unified 64-bit memory. It sits between `ARM_CPU` and the memory model, replacing the split instruction-memory/data-memory hookup. Data accesses have priority, and a starvation counter guarantees fetch progress. Each access holds the memory bus for a fixed `MEM_LAT` cycles, then returns data (or a write acknowledge) to the winning requester.

## Interface
- `ADDR_W`, 64, address width for both requesters and memory
- `DATA_W`, 64, memory data width
- `MEM_LAT`, 2, cycles the memory bus is held per access (legal range 1–15)
- `STARVE_MAX`, 4, consecutive data grants allowed while a fetch waits (legal range 1–15)

- `CLOCK` in 1: single clock; all state changes on the rising edge
- `RESET` in 1: asynchronous, active-high reset
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`
- `if_addr` in ADDR_W: fetch byte address (PC)
- `if_gnt` out 1: one-cycle fetch grant pulse
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid
- `if_rdata` out 32: fetched instruction word
- `d_req` in 1: data request; held with `d_we`, `d_addr`, `d_wdata` until `d_gnt`
- `d_we` in 1: 1 = store, 0 = load
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: store data
- `d_gnt` out 1: one-cycle data grant pulse
- `d_rvalid` out 1: one-cycle pulse; load data valid, or store complete
- `d_rdata` out DATA_W: load data
- `mem_address` out ADDR_W: memory address
- `mem_data_in` out DATA_W: memory write data
- `control_memwrite` out 1: memory write enable
- `control_memread` out 1: memory read enable
- `mem_data_out` in DATA_W: memory read data

## Operation
- **States:**
  - IDLE: no access in progress.
  - ACCESS: an access is in progress; down-counter `cnt` runs for the access duration.
  - `owner` register: which requester holds the bus (fetch or data).
  - `starve` register: 4-bit counter of data grants made while a fetch was waiting.
- **Arbitration in IDLE** (sampled at the clock edge):
  - Only `d_req`: grant data.
  - Only `if_req`: grant fetch.
  - Both, with `starve` < `STARVE_MAX`: grant data and increment `starve`.
  - Both, with `starve` == `STARVE_MAX`: grant fetch.
  - Any fetch grant clears `starve`.
  - A data grant made while `if_req` is low clears `starve`.
- **On a grant:**
  - Register the winner's address, write data and write flag.
  - Pulse the matching `*_gnt` for one cycle.
  - Enter ACCESS with `cnt` = `MEM_LAT`.
- **In ACCESS:**
  - Memory outputs are driven from registers and held constant.
  - `control_memread` = !we; `control_memwrite` = we.
  - Fetch accesses always read; `mem_data_in` = 0 for them.
  - `cnt` decrements each cycle.
- **At the edge where `cnt` == 1:**
  - Capture `mem_data_out`.
  - Fetch owner: `if_rdata` = `if_addr[2]` ? `mem_data_out[63:32]` : `mem_data_out[31:0]`.
  - Data owner: load data goes to `d_rdata`; a store leaves `d_rdata` unchanged.
  - Pulse the owner's `*_rvalid` for one cycle.
  - Drop memory enables to 0.
  - Return to IDLE.
- **Requests during ACCESS** are ignored; a requester keeps `req` high and is arbitrated in the next IDLE cycle.
- Addresses pass through unmodified; no alignment checks.

## Timing
- Request sampled in IDLE at edge E0:
  - `gnt` is high in cycle 1 (after E0).
  - Memory enables are high in cycles 1..`MEM_LAT`.
  - `rvalid` is high in cycle `MEM_LAT`+1.
- The `rvalid` cycle is an IDLE cycle, so a new request can be sampled then. Back-to-back throughput is one access per `MEM_LAT`+1 cycles.
- `gnt` and `rvalid` never coincide for the same requester. Only one `rvalid` is high in any cycle.
- **Reset values** (`RESET` high, asynchronous, all outputs at once):
  - `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `control_memread`, `control_memwrite`: 0.
  - `mem_address`, `mem_data_in`, `if_rdata`, `d_rdata`: 0.
  - State IDLE, `starve` = 0.
- **Reset mid-access:** the access is abandoned, no `rvalid` is produced, and enables drop immediately.
- **Release:** after `RESET` is released, arbitration begins at the first rising edge.

## Test plan
- **Lone load:** reset; `d_req`=1, `d_we`=0, `d_addr`=0x40, `MEM_LAT`=2, memory returns 0xDEADBEEF_CAFEF00D.
  -> `d_gnt` in cycle 1; `control_memread` in cycles 1–2 with `mem_address`=0x40; `d_rvalid` in cycle 3 with `d_rdata`=0xDEADBEEF_CAFEF00D.
- **Store:** `d_we`=1, `d_addr`=0x10, `d_wdata`=0x1234.
  -> `control_memwrite` in cycles 1–2 with `mem_data_in`=0x1234; `d_rvalid` pulses in cycle 3; `d_rdata` unchanged.
- **Fetch word select:** `if_addr`=0x4, memory word 0xAAAAAAAA_55555555.
  -> `if_rdata`=0xAAAAAAAA.
  - Repeat with `if_addr`=0x0 -> `if_rdata`=0x55555555.
- **Starvation:** `if_req` and `d_req` held continuously, `STARVE_MAX`=4.
  -> grant order D, D, D, D, F, D, D, D, D, F; grants spaced `MEM_LAT`+1 cycles apart.
- **Reset mid-access:** assert `RESET` in cycle 2 of a load.
  -> all outputs 0 in the same cycle; no `d_rvalid`; after release, a pending `if_req` is granted at the first edge.
